// File: rtl/if_id_buffer.sv
// Two-entry IF/ID decoupling FIFO with valid/ready on both sides and branch flush.
// Optional IFID_STATS_EN adds saturating stall and flush counters.
module if_id_buffer #(
   parameter int                 LARGURA   = 32,
   parameter logic [LARGURA-1:0] NOP_INSTR = '0
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valido,
   output logic               in_pronto,
   input  logic [LARGURA-1:0] pc4_in,
   input  logic [LARGURA-1:0] instrucao_in,
   input  logic               flush,
   output logic               out_valido,
   input  logic               out_pronto,
   output logic [LARGURA-1:0] pc4_out,
   output logic [LARGURA-1:0] instrucao_out
`ifdef IFID_STATS_EN
   ,
   output logic [15:0]        stall_ciclos,
   output logic [15:0]        flush_total
`endif
);

   logic [LARGURA-1:0] pc4_mem   [2];
   logic [LARGURA-1:0] instr_mem [2];
   logic               wr_ptr;
   logic               rd_ptr;
   logic [1:0]         count;
   logic               push;
   logic               pop;

   // Ready depends only on registered occupancy, so decode's ready never reaches fetch.
   assign in_pronto  = (count != 2'd2) && !reset;
   assign out_valido = (count != 2'd0);
   assign push       = in_valido && in_pronto;
   assign pop        = out_valido && out_pronto;

   assign pc4_out       = out_valido ? pc4_mem[rd_ptr]   : '0;
   assign instrucao_out = out_valido ? instr_mem[rd_ptr] : NOP_INSTR;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else if (flush) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; stale entries are unreachable once count is cleared.
   always_ff @(posedge clock) begin
      if (push && !flush) begin
         pc4_mem[wr_ptr]   <= pc4_in;
         instr_mem[wr_ptr] <= instrucao_in;
      end
   end

`ifdef IFID_STATS_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stall_ciclos <= 16'd0;
         flush_total  <= 16'd0;
      end else begin
         if (out_valido && !out_pronto) stall_ciclos <= sat_inc(stall_ciclos);
         if (flush)                     flush_total  <= sat_inc(flush_total);
      end
   end
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Randomized scoreboard bench for if_id_buffer: a queue model tracks expected FIFO contents,
// a negedge monitor compares every cycle. Stats counters are checked when IFID_STATS_EN is set.
module tb_if_id_buffer;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valido;
   logic        in_pronto;
   logic [31:0] pc4_in;
   logic [31:0] instrucao_in;
   logic        flush;
   logic        out_valido;
   logic        out_pronto;
   logic [31:0] pc4_out;
   logic [31:0] instrucao_out;
`ifdef IFID_STATS_EN
   logic [15:0] stall_ciclos;
   logic [15:0] flush_total;
   int          m_stall;
   int          m_flush;
`endif

   int          errors = 0;
   int          checks = 0;
   bit          chk_en = 1'b0;
   logic [63:0] q[$];

   if_id_buffer #(.LARGURA(32), .NOP_INSTR(NOP)) dut (
      .clock(clock), .reset(reset),
      .in_valido(in_valido), .in_pronto(in_pronto),
      .pc4_in(pc4_in), .instrucao_in(instrucao_in),
      .flush(flush),
      .out_valido(out_valido), .out_pronto(out_pronto),
      .pc4_out(pc4_out), .instrucao_out(instrucao_out)
`ifdef IFID_STATS_EN
      , .stall_ciclos(stall_ciclos), .flush_total(flush_total)
`endif
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus; the model decides push/pop from its own occupancy.
   task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic op, input logic fl);
      bit do_push;
      bit do_pop;
      in_valido = iv; pc4_in = pc; instrucao_in = ins; out_pronto = op; flush = fl;
      do_push = iv && (q.size() < 2);
      do_pop  = op && (q.size() != 0);
      @(posedge clock);
`ifdef IFID_STATS_EN
      if (q.size() != 0 && !op && m_stall < 65535) m_stall++;
      if (fl && m_flush < 65535) m_flush++;
`endif
      if (fl) q.delete();
      else begin
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back({pc, ins});
      end
      #2;
   endtask

   always @(negedge clock) begin
      if (chk_en) begin
         chk("in_pronto", {63'd0, in_pronto}, {63'd0, q.size() < 2});
         chk("out_valido", {63'd0, out_valido}, {63'd0, q.size() != 0});
         if (q.size() != 0) begin
            chk("pc4_out", {32'd0, pc4_out}, {32'd0, q[0][63:32]});
            chk("instrucao_out", {32'd0, instrucao_out}, {32'd0, q[0][31:0]});
         end else begin
            chk("pc4_out_empty", {32'd0, pc4_out}, 64'd0);
            chk("instrucao_out_empty", {32'd0, instrucao_out}, {32'd0, NOP});
         end
`ifdef IFID_STATS_EN
         chk("stall_ciclos", {48'd0, stall_ciclos}, 64'(m_stall));
         chk("flush_total", {48'd0, flush_total}, 64'(m_flush));
`endif
      end
   end

   initial begin
      reset = 1'b1; in_valido = 1'b0; pc4_in = '0; instrucao_in = '0;
      flush = 1'b0; out_pronto = 1'b0;
`ifdef IFID_STATS_EN
      m_stall = 0; m_flush = 0;
`endif
      #3;
      chk("rst_out_valido", {63'd0, out_valido}, 64'd0);
      chk("rst_in_pronto", {63'd0, in_pronto}, 64'd0);
      chk("rst_pc4_out", {32'd0, pc4_out}, 64'd0);
      chk("rst_instrucao_out", {32'd0, instrucao_out}, {32'd0, NOP});
      @(posedge clock); #2;
      reset = 1'b0;
      chk_en = 1'b1;

      // First word appears one edge after the push
      step(1'b1, 32'd4, 32'h1111_1111, 1'b0, 1'b0);
      chk("lat_out_valido", {63'd0, out_valido}, 64'd1);
      chk("lat_pc4_out", {32'd0, pc4_out}, 64'd4);
      chk("lat_instr", {32'd0, instrucao_out}, 64'h1111_1111);

      // Fill, third push ignored, then drain in order
      step(1'b1, 32'd8, 32'h2222_2222, 1'b0, 1'b0);
      chk("full_in_pronto", {63'd0, in_pronto}, 64'd0);
      step(1'b1, 32'd12, 32'h3333_3333, 1'b0, 1'b0);
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      chk("drain_pc4_8", {32'd0, pc4_out}, 64'd8);
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      chk("drain_empty", {63'd0, out_valido}, 64'd0);

      // Flush while holding 4, 8 with a concurrent push of 12
      step(1'b1, 32'd4, 32'hAAAA_0004, 1'b0, 1'b0);
      step(1'b1, 32'd8, 32'hAAAA_0008, 1'b0, 1'b0);
      step(1'b1, 32'd12, 32'hAAAA_000C, 1'b0, 1'b1);
      chk("flush_out_valido", {63'd0, out_valido}, 64'd0);
      chk("flush_nop", {32'd0, instrucao_out}, {32'd0, NOP});
      // Flush at count=1 discards simultaneous push and pop
      step(1'b1, 32'd20, 32'hBBBB_0014, 1'b0, 1'b0);
      step(1'b1, 32'd24, 32'hBBBB_0018, 1'b1, 1'b1);
      chk("flush_pp_empty", {63'd0, out_valido}, 64'd0);

      // Steady stream: one word per cycle, ready stays high
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 32'(100 + 4 * i), $urandom, 1'b1, 1'b0);
         chk("stream_in_pronto", {63'd0, in_pronto}, 64'd1);
      end

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      end

      // Asynchronous reset between edges while full
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
      step(1'b1, 32'd40, 32'hCCCC_0028, 1'b0, 1'b0);
      step(1'b1, 32'd44, 32'hCCCC_002C, 1'b0, 1'b0);
      in_valido = 1'b0; out_pronto = 1'b0;
      chk_en = 1'b0;
      #1 reset = 1'b1;
      #1;
      chk("arst_out_valido", {63'd0, out_valido}, 64'd0);
      chk("arst_in_pronto", {63'd0, in_pronto}, 64'd0);
      chk("arst_pc4_out", {32'd0, pc4_out}, 64'd0);
      chk("arst_instr", {32'd0, instrucao_out}, {32'd0, NOP});
      q.delete();
`ifdef IFID_STATS_EN
      m_stall = 0; m_flush = 0;
`endif
      @(posedge clock); #2;
      reset = 1'b0;
      chk_en = 1'b1;
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      chk("post_rst_empty", {63'd0, out_valido}, 64'd0);

`ifdef IFID_STATS_EN
      // Five stalled cycles on a valid head, then two flushes
      step(1'b1, 32'd60, 32'hDDDD_003C, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
      step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
      chk("stats_stall_5", {48'd0, stall_ciclos}, 64'd5);
      chk("stats_flush_2", {48'd0, flush_total}, 64'd2);
`endif

      step(1'b1, 32'd80, 32'hEEEE_0050, 1'b0, 1'b0);
      chk("final_pc4", {32'd0, pc4_out}, 64'd80);
      @(negedge clock);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
